// File: rtl/rr_packet_arbiter.sv
// Round-robin packet arbiter: N valid/ready requesters muxed onto one output with a zero-latency data path.
// Define RR_PACKET_LOCK_EN to hold the grant for a whole packet; otherwise every beat re-arbitrates.
module rr_packet_arbiter #(
  parameter int unsigned INPUTS     = 4,
  parameter int unsigned DATA_WIDTH = 16
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [INPUTS-1:0]            in_valid,
  output logic [INPUTS-1:0]            in_ready,
  input  logic [INPUTS*DATA_WIDTH-1:0] in_data,
  input  logic [INPUTS-1:0]            in_last,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [DATA_WIDTH-1:0]        out_data,
  output logic                         out_last,
  output logic [INPUTS-1:0]            grant,
  output logic                         busy
);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t            state_q;
  logic [INPUTS-1:0] gnt_q;
  logic [INPUTS-1:0] ptr_q;
  logic [INPUTS-1:0] req_hi;
  logic [INPUTS-1:0] hi_pick;
  logic [INPUTS-1:0] lo_pick;
  logic [INPUTS-1:0] rr_pick;
  logic [INPUTS-1:0] ptr_rot;
  logic              eff_last;
  logic              xfer;
  logic              pkt_end;

  // Requesters at or above the pointer win; otherwise wrap to the lowest valid index.
  assign req_hi  = in_valid & ~(ptr_q - INPUTS'(1));
  assign hi_pick = req_hi & (~req_hi + INPUTS'(1));
  assign lo_pick = in_valid & (~in_valid + INPUTS'(1));
  assign rr_pick = (|req_hi) ? hi_pick : lo_pick;

  assign grant = (state_q == BUSY) ? gnt_q : rr_pick;

  // AND-OR selection: all-zero payload when nothing is granted.
  always_comb begin
    out_data = '0;
    out_last = 1'b0;
    for (int i = 0; i < INPUTS; i++) begin
      out_data = out_data | (in_data[i*DATA_WIDTH +: DATA_WIDTH] & {DATA_WIDTH{grant[i]}});
      out_last = out_last | (in_last[i] & grant[i]);
    end
  end

  assign out_valid = |(grant & in_valid);
  assign in_ready  = grant & {INPUTS{out_ready}};
  assign xfer      = out_valid & out_ready;

`ifdef RR_PACKET_LOCK_EN
  assign eff_last = out_last;
`else
  assign eff_last = 1'b1;
`endif

  assign pkt_end = xfer & eff_last;
  assign ptr_rot = {grant[INPUTS-2:0], grant[INPUTS-1]};

  // Lock the grant while a packet (or a stalled beat) is in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      ptr_q   <= INPUTS'(1);
      busy    <= 1'b0;
    end else begin
      if (pkt_end) begin
        ptr_q <= ptr_rot;
      end
      unique case (state_q)
        IDLE: begin
          if (out_valid && !pkt_end) begin
            state_q <= BUSY;
            gnt_q   <= grant;
            busy    <= 1'b1;
          end
        end
        BUSY: begin
          if (pkt_end) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            busy    <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rr_packet_arbiter.sv
// Randomised bench for rr_packet_arbiter against an index-based arbitration model.
module tb_rr_packet_arbiter;

  localparam int unsigned N  = 4;
  localparam int unsigned DW = 16;
`ifdef RR_PACKET_LOCK_EN
  localparam bit LOCK = 1'b1;
`else
  localparam bit LOCK = 1'b0;
`endif

  logic              clk;
  logic              rst_n;
  logic [N-1:0]      in_valid;
  logic [N-1:0]      in_ready;
  logic [N*DW-1:0]   in_data;
  logic [N-1:0]      in_last;
  logic              out_valid;
  logic              out_ready;
  logic [DW-1:0]     out_data;
  logic              out_last;
  logic [N-1:0]      grant;
  logic              busy;

  int checks;
  int errs;
  int ptr_idx;
  bit locked;
  int lock_idx;
  logic [N-1:0] last_grant;

  rr_packet_arbiter #(.INPUTS(N), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .grant(grant), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Model: first valid index scanning upward from the priority index, with wrap.
  function automatic int model_pick(input logic [N-1:0] v);
    for (int k = 0; k < N; k++) begin
      int idx;
      idx = (ptr_idx + k) % N;
      if (v[idx]) return idx;
    end
    return -1;
  endfunction

  task automatic model_reset();
    ptr_idx  = 0;
    locked   = 1'b0;
    lock_idx = 0;
  endtask

  task automatic cycle(input logic [N-1:0] v, input logic [N-1:0] l, input logic r);
    int g;
    logic ev, el, xf, done;
    logic [N-1:0] eg;
    logic [DW-1:0] ed;
    @(negedge clk);
    in_valid  = v;
    in_last   = l;
    out_ready = r;
    in_data   = {$urandom, $urandom};
    #1;
    g  = locked ? lock_idx : model_pick(v);
    eg = '0;
    ed = '0;
    ev = 1'b0;
    el = 1'b0;
    if (g >= 0) begin
      eg = N'(1 << g);
      ed = in_data[g*DW +: DW];
      ev = v[g];
      el = l[g];
    end
    check("grant", grant, eg);
    check("out_valid", out_valid, ev);
    check("out_data", out_data, ed);
    check("out_last", out_last, el);
    check("in_ready", in_ready, eg & {N{r}});
    last_grant = grant;
    @(posedge clk);
    xf   = ev & r;
    done = xf & (LOCK ? el : 1'b1);
    if (!locked) begin
      if (ev && !done) begin
        locked   = 1'b1;
        lock_idx = g;
      end
    end else if (done) begin
      locked = 1'b0;
    end
    if (done) ptr_idx = (g + 1) % N;
    #1;
    check("busy", busy, locked);
  endtask

  initial begin
    checks    = 0;
    errs      = 0;
    in_valid  = '0;
    in_last   = '0;
    in_data   = '0;
    out_ready = 1'b0;
    rst_n     = 1'b0;
    model_reset();
    #1;
    check("rst_busy", busy, 1'b0);
    check("rst_grant", grant, '0);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_in_ready", in_ready, '0);
    #12;
    rst_n = 1'b1;

    // Single-beat packets after reset: input 1 then input 2.
    cycle(4'b0110, 4'b1111, 1'b1);
    check("first_grant", last_grant, 4'b0010);
    cycle(4'b0110, 4'b1111, 1'b1);
    check("second_grant", last_grant, 4'b0100);

    // Three-beat packet from input 2 with competitors present.
    cycle(4'b0100, 4'b0000, 1'b1);
    cycle(4'b1111, 4'b0000, 1'b1);
    cycle(4'b1111, 4'b0100, 1'b1);
    cycle(4'b1111, 4'b1111, 1'b1);

    // Stall on input 1 while input 0 joins.
    cycle(4'b0010, 4'b0010, 1'b0);
    check("stall_grant0", last_grant, 4'b0010);
    for (int s = 0; s < 4; s++) begin
      cycle(4'b0011, 4'b0011, 1'b0);
      check("stall_grant", last_grant, 4'b0010);
    end
    cycle(4'b0011, 4'b0011, 1'b1);

    // Two-beat packets from inputs 0 and 1.
    for (int p = 0; p < 2; p++) begin
      cycle(4'b0011, 4'b0000, 1'b1);
      cycle(4'b0011, 4'b0011, 1'b1);
    end
    cycle(4'b1111, 4'b1111, 1'b1);

    // Wrap from the top index back to input 0.
    cycle(4'b1000, 4'b1000, 1'b1);
    cycle(4'b0001, 4'b0001, 1'b1);
    check("wrap_grant", last_grant, 4'b0001);

    // Random traffic, including valid drops mid-packet.
    for (int n = 0; n < 600; n++) begin
      logic [N-1:0] rl;
      for (int b = 0; b < N; b++) rl[b] = ($urandom_range(0, 2) == 0);
      cycle(N'($urandom_range(0, 15)), rl, 1'($urandom_range(0, 3) != 0));
    end
    cycle(4'b1111, 4'b1111, 1'b1);

    // Reset in the middle of a packet from input 3.
    cycle(4'b1000, 4'b0000, 1'b0);
    check("pre_rst_busy", busy, 1'b1);
    @(negedge clk);
    in_valid = '0;
    rst_n    = 1'b0;
    #1;
    model_reset();
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_grant", grant, '0);
    check("mid_rst_in_ready", in_ready, '0);
    @(negedge clk);
    rst_n = 1'b1;
    cycle(4'b1001, 4'b1001, 1'b1);
    check("post_rst_grant", last_grant, 4'b0001);
    cycle(4'b1001, 4'b1001, 1'b1);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
